// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared states, field limits and wrap helpers for the clock controller
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam logic [7:0]  MAX_HOUR    = 8'd23;
  localparam logic [7:0]  MAX_MIN     = 8'd59;
  localparam logic [7:0]  MAX_SEC     = 8'd59;
  localparam int unsigned SEC_PER_DAY = 86400;

  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
    return (v >= max) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [7:0] wrap_dec(input logic [7:0] v, input logic [7:0] max);
    return (v == 8'd0 || v > max) ? max : v - 8'd1;
  endfunction

endpackage

// File: rtl/hms_to_stamp.sv
// rtl/hms_to_stamp.sv - registered hour/min/sec to seconds-of-day conversion
module hms_to_stamp
  import clock_pkg::*;
#(
  parameter logic [31:0] RESET_STAMP = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  hour,
  input  logic [7:0]  min,
  input  logic [7:0]  sec,
  output logic [31:0] stamp
);

  logic [31:0] stamp_n;

  always_comb begin
    stamp_n = 32'(hour) * 32'd3600 + 32'(min) * 32'd60 + 32'(sec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp <= RESET_STAMP;
    end else begin
      stamp <= stamp_n;
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - time-of-day counter with field editing, validated load and stamp
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0,
  parameter int RESET_SEC  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        load_valid,
  input  logic [7:0]  load_hour,
  input  logic [7:0]  load_min,
  input  logic [7:0]  load_sec,
  output logic [7:0]  hour,
  output logic [7:0]  min,
  output logic [7:0]  sec,
  output logic [31:0] stamp,
  output logic [1:0]  mode,
  output logic        day_wrap,
  output logic        load_err
);

  localparam logic [31:0] RESET_STAMP = 32'(RESET_HOUR * 3600 + RESET_MIN * 60 + RESET_SEC);

  state_t     state, state_n;
  logic [7:0] hour_n, min_n, sec_n;
  logic       day_wrap_n, load_err_n;
  logic       load_ok;

  assign load_ok = (load_hour <= MAX_HOUR) && (load_min <= MAX_MIN) && (load_sec <= MAX_SEC);

  // Strict priority chain: only the first matching event acts, the rest are dropped.
  always_comb begin
    state_n    = state;
    hour_n     = hour;
    min_n      = min;
    sec_n      = sec;
    day_wrap_n = 1'b0;
    load_err_n = 1'b0;
    if (load_valid) begin
      if (load_ok) begin
        hour_n  = load_hour;
        min_n   = load_min;
        sec_n   = load_sec;
        state_n = RUN;
      end else begin
        load_err_n = 1'b1;
      end
    end else if (btn_mode) begin
      case (state)
        RUN:     state_n = SET_H;
        SET_H:   state_n = SET_M;
        SET_M:   state_n = SET_S;
        default: state_n = RUN;
      endcase
    end else if (state != RUN) begin
      // Edit states freeze the clock; inc and dec together cancel out.
      if (btn_inc ^ btn_dec) begin
        case (state)
          SET_H:   hour_n = btn_inc ? wrap_inc(hour, MAX_HOUR) : wrap_dec(hour, MAX_HOUR);
          SET_M:   min_n  = btn_inc ? wrap_inc(min, MAX_MIN)   : wrap_dec(min, MAX_MIN);
          SET_S:   sec_n  = btn_inc ? wrap_inc(sec, MAX_SEC)   : wrap_dec(sec, MAX_SEC);
          default: ;
        endcase
      end
    end else if (tick_1hz) begin
      sec_n = wrap_inc(sec, MAX_SEC);
      if (sec == MAX_SEC) begin
        min_n = wrap_inc(min, MAX_MIN);
        if (min == MAX_MIN) begin
          hour_n = wrap_inc(hour, MAX_HOUR);
          if (hour == MAX_HOUR) begin
            day_wrap_n = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      hour     <= 8'(RESET_HOUR);
      min      <= 8'(RESET_MIN);
      sec      <= 8'(RESET_SEC);
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      hour     <= hour_n;
      min      <= min_n;
      sec      <= sec_n;
      day_wrap <= day_wrap_n;
      load_err <= load_err_n;
    end
  end

  assign mode = state;

  hms_to_stamp #(
    .RESET_STAMP(RESET_STAMP)
  ) u_stamp (
    .clk  (clk),
    .rst  (rst),
    .hour (hour),
    .min  (min),
    .sec  (sec),
    .stamp(stamp)
  );

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - table-driven bench for clock_time_ctrl
module tb_clock_time_ctrl;

  logic        clk = 1'b0;
  logic        rst, tick_1hz, btn_mode, btn_inc, btn_dec, load_valid;
  logic [7:0]  load_hour, load_min, load_sec;
  logic [7:0]  hour, min, sec;
  logic [31:0] stamp;
  logic [1:0]  mode;
  logic        day_wrap, load_err;

  always #5 clk = ~clk;

  clock_time_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .load_valid(load_valid),
    .load_hour (load_hour),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .hour      (hour),
    .min       (min),
    .sec       (sec),
    .stamp     (stamp),
    .mode      (mode),
    .day_wrap  (day_wrap),
    .load_err  (load_err)
  );

  // control bits: {rst, tick, mode, inc, dec, load}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_RST  = 6'b100000;
  localparam logic [5:0] C_TK   = 6'b010000;
  localparam logic [5:0] C_MD   = 6'b001000;
  localparam logic [5:0] C_INC  = 6'b000100;
  localparam logic [5:0] C_DEC  = 6'b000010;
  localparam logic [5:0] C_LD   = 6'b000001;

  typedef struct {
    logic [5:0] ctl;
    logic [7:0] lh, lm, ls;
    logic [7:0] eh, em, es;
    logic [1:0] emode;
    logic       edw, ele;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic [5:0] ctl, input logic [7:0] lh, lm, ls,
                     input logic [7:0] eh, em, es, input logic [1:0] emode,
                     input logic edw, ele);
    vec_t v;
    v.ctl = ctl; v.lh = lh; v.lm = lm; v.ls = ls;
    v.eh = eh; v.em = em; v.es = es; v.emode = emode; v.edw = edw; v.ele = ele;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    tick_1hz = 0; btn_mode = 0; btn_inc = 0; btn_dec = 0; load_valid = 0;
    load_hour = 0; load_min = 0; load_sec = 0;
  endtask

  logic [31:0] exp_stamp;
  logic [31:0] prev_hms;

  initial begin
    rst = 1'b1;
    drive_idle();

    add(C_RST,  0, 0, 0,    0, 0, 0,   0, 0, 0);
    add(C_RST,  0, 0, 0,    0, 0, 0,   0, 0, 0);
    add(C_NONE, 0, 0, 0,    0, 0, 0,   0, 0, 0);
    add(C_TK,   0, 0, 0,    0, 0, 1,   0, 0, 0);
    add(C_TK,   0, 0, 0,    0, 0, 2,   0, 0, 0);
    add(C_TK,   0, 0, 0,    0, 0, 3,   0, 0, 0);
    add(C_NONE, 0, 0, 0,    0, 0, 3,   0, 0, 0);
    add(C_LD,   23, 59, 59, 23, 59, 59, 0, 0, 0);
    add(C_NONE, 0, 0, 0,    23, 59, 59, 0, 0, 0);
    add(C_TK,   0, 0, 0,    0, 0, 0,   0, 1, 0);
    add(C_NONE, 0, 0, 0,    0, 0, 0,   0, 0, 0);
    add(C_MD,   0, 0, 0,    0, 0, 0,   1, 0, 0);
    add(C_DEC,  0, 0, 0,    23, 0, 0,  1, 0, 0);
    add(C_TK,   0, 0, 0,    23, 0, 0,  1, 0, 0);
    add(C_MD,   0, 0, 0,    23, 0, 0,  2, 0, 0);
    add(C_MD,   0, 0, 0,    23, 0, 0,  3, 0, 0);
    add(C_MD,   0, 0, 0,    23, 0, 0,  0, 0, 0);
    add(C_MD,   0, 0, 0,    23, 0, 0,  1, 0, 0);
    add(C_LD,   12, 60, 0,  23, 0, 0,  1, 0, 1);
    add(C_LD | C_MD | C_TK, 12, 30, 45, 12, 30, 45, 0, 0, 0);
    add(C_NONE, 0, 0, 0,    12, 30, 45, 0, 0, 0);
    add(C_LD,   24, 0, 0,   12, 30, 45, 0, 0, 1);
    add(C_LD,   0, 0, 60,   12, 30, 45, 0, 0, 1);
    add(C_LD,   12, 59, 10, 12, 59, 10, 0, 0, 0);
    add(C_MD,   0, 0, 0,    12, 59, 10, 1, 0, 0);
    add(C_MD,   0, 0, 0,    12, 59, 10, 2, 0, 0);
    add(C_INC,  0, 0, 0,    12, 0, 10,  2, 0, 0);
    add(C_DEC,  0, 0, 0,    12, 59, 10, 2, 0, 0);
    add(C_INC | C_DEC, 0, 0, 0, 12, 59, 10, 2, 0, 0);
    add(C_MD | C_INC,  0, 0, 0, 12, 59, 10, 3, 0, 0);
    add(C_INC,  0, 0, 0,    12, 59, 11, 3, 0, 0);
    add(C_TK,   0, 0, 0,    12, 59, 11, 3, 0, 0);
    add(C_MD,   0, 0, 0,    12, 59, 11, 0, 0, 0);
    add(C_MD,   0, 0, 0,    12, 59, 11, 1, 0, 0);
    add(C_MD,   0, 0, 0,    12, 59, 11, 2, 0, 0);
    add(C_RST,  0, 0, 0,    0, 0, 0,   0, 0, 0);
    add(C_MD,   0, 0, 0,    0, 0, 0,   1, 0, 0);
    add(C_DEC,  0, 0, 0,    23, 0, 0,  1, 0, 0);
    add(C_INC,  0, 0, 0,    0, 0, 0,   1, 0, 0);
    add(C_LD,   1, 59, 59,  1, 59, 59, 0, 0, 0);
    add(C_TK,   0, 0, 0,    2, 0, 0,   0, 0, 0);
    add(C_INC,  0, 0, 0,    2, 0, 0,   0, 0, 0);
    add(C_DEC,  0, 0, 0,    2, 0, 0,   0, 0, 0);

    prev_hms = 32'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst        = vecs[i].ctl[5];
      tick_1hz   = vecs[i].ctl[4];
      btn_mode   = vecs[i].ctl[3];
      btn_inc    = vecs[i].ctl[2];
      btn_dec    = vecs[i].ctl[1];
      load_valid = vecs[i].ctl[0];
      load_hour  = vecs[i].lh;
      load_min   = vecs[i].lm;
      load_sec   = vecs[i].ls;
      @(posedge clk);
      #1;
      // stamp reflects the time held before this edge, or the reset value
      exp_stamp = vecs[i].ctl[5] ? 32'd0 : prev_hms;
      prev_hms  = 32'(vecs[i].eh) * 3600 + 32'(vecs[i].em) * 60 + 32'(vecs[i].es);
      n_vec++;
      chk("hour",     i, 32'(hour),     32'(vecs[i].eh));
      chk("min",      i, 32'(min),      32'(vecs[i].em));
      chk("sec",      i, 32'(sec),      32'(vecs[i].es));
      chk("mode",     i, 32'(mode),     32'(vecs[i].emode));
      chk("day_wrap", i, 32'(day_wrap), 32'(vecs[i].edw));
      chk("load_err", i, 32'(load_err), 32'(vecs[i].ele));
      chk("stamp",    i, stamp,         exp_stamp);
    end

    // asynchronous reset takes effect before the next clock edge
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    btn_mode = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    chk("async_pre_mode", 100, 32'(mode), 32'd1);
    @(negedge clk);
    btn_mode = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    chk("async_mode",  101, 32'(mode),  32'd0);
    chk("async_hour",  101, 32'(hour),  32'd0);
    chk("async_stamp", 101, stamp,      32'd0);

    // inputs are ignored while reset is held
    @(negedge clk);
    btn_mode = 1'b1; tick_1hz = 1'b1; load_valid = 1'b1;
    load_hour = 8'd5; load_min = 8'd5; load_sec = 8'd5;
    @(posedge clk);
    #1;
    n_vec++;
    chk("rst_hold_mode", 102, 32'(mode), 32'd0);
    chk("rst_hold_hour", 102, 32'(hour), 32'd0);
    chk("rst_hold_sec",  102, 32'(sec),  32'd0);
    chk("rst_hold_err",  102, 32'(load_err), 32'd0);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    chk("post_rst_sec", 103, 32'(sec), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
